// File: rtl/scan_sram_loader_pkg.sv
// Shared parameters, FSM state type and write payload for the scan-driven SRAM loader.
package scan_sram_loader_pkg;

    localparam int unsigned SRAM_WORD_LENGTH = 32;
    localparam int unsigned SRAM_ADDR_WIDTH  = 8;
    localparam int unsigned FRAME_LEN        = SRAM_WORD_LENGTH + SRAM_ADDR_WIDTH;
    localparam int unsigned CNT_W            = $clog2(FRAME_LEN + 1);
    localparam int unsigned FRAMES_W         = SRAM_ADDR_WIDTH + 1;
    localparam int unsigned SYNC_STAGES      = 2;

    typedef enum logic [1:0] {
        LD_SHIFT = 2'd0,
        LD_WRITE = 2'd1,
        LD_DONE  = 2'd2
    } ld_state_t;

    // Field order matches the shift register: address bits sit above the word bits.
    typedef struct packed {
        logic [SRAM_ADDR_WIDTH-1:0]  addr;
        logic [SRAM_WORD_LENGTH-1:0] data;
    } wr_frame_t;

endpackage

// File: rtl/scan_sram_loader_if.sv
// SRAM write-port bundle between the loader (master) and the SRAM (slave).
interface scan_sram_loader_if;
    import scan_sram_loader_pkg::*;

    logic                        o_wr_valid;
    logic                        i_wr_ready;
    logic [SRAM_ADDR_WIDTH-1:0]  o_wr_addr;
    logic [SRAM_WORD_LENGTH-1:0] o_wr_data;

    modport master (
        output o_wr_valid,
        output o_wr_addr,
        output o_wr_data,
        input  i_wr_ready
    );

    modport slave (
        input  o_wr_valid,
        input  o_wr_addr,
        input  o_wr_data,
        output i_wr_ready
    );

endinterface

// File: rtl/scan_sram_loader_sync_edge_det.sv
// Synchroniser chain for one scan pin, with rise/fall detection on the synced level.
module scan_sram_loader_sync_edge_det #(
    parameter int unsigned STAGES = 2
) (
    input  logic CLK,
    input  logic RESETn,
    input  logic i_d,
    output logic o_level,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= STAGES'({r_sync, i_d});
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level  = r_sync[STAGES-1];
    assign o_rise_c = r_sync[STAGES-1] & ~r_prev;
    assign o_fall_c = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/scan_sram_loader.sv
// Deserialises scan frames into {word, address} and writes them to SRAM until the
// all-ones end-of-init frame arrives.
module scan_sram_loader
    import scan_sram_loader_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic                  SC_CLK,
    input  logic                  SC_EN,
    input  logic                  scanIn,
    scan_sram_loader_if.master    wr,
    output logic                  o_init_done,
    output logic                  o_frame_err,
    output logic [FRAMES_W-1:0]   o_frames
);

    localparam logic [1:0] ST_SHIFT = 2'(LD_SHIFT);
    localparam logic [1:0] ST_WRITE = 2'(LD_WRITE);
    localparam logic [1:0] ST_DONE  = 2'(LD_DONE);

    logic w_sc_rise;
    logic w_en_level;
    logic w_en_fall;
    logic w_si;
    logic w_unused_edges;
    logic w_clk_level;
    logic w_clk_fall;
    logic w_en_rise;
    logic w_si_rise;
    logic w_si_fall;

    scan_sram_loader_sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .i_d      (SC_CLK),
        .o_level  (w_clk_level),
        .o_rise_c (w_sc_rise),
        .o_fall_c (w_clk_fall)
    );

    scan_sram_loader_sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_en (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .i_d      (SC_EN),
        .o_level  (w_en_level),
        .o_rise_c (w_en_rise),
        .o_fall_c (w_en_fall)
    );

    scan_sram_loader_sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_si (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .i_d      (scanIn),
        .o_level  (w_si),
        .o_rise_c (w_si_rise),
        .o_fall_c (w_si_fall)
    );

    assign w_unused_edges = ^{w_clk_level, w_clk_fall, w_en_rise, w_si_rise, w_si_fall};

    logic [1:0]           r_state;
    logic [FRAME_LEN-1:0] r_shreg;
    logic [CNT_W-1:0]     r_cnt;
    wr_frame_t            r_hold;
    logic                 r_valid;
    logic                 r_init_done;
    logic                 r_frame_err;
    logic [FRAMES_W-1:0]  r_frames;
    logic                 r_done_pend;

    logic [1:0]           w_state_nxt;
    logic [FRAME_LEN-1:0] w_shreg_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    wr_frame_t            w_hold_nxt;
    logic                 w_valid_nxt;
    logic                 w_init_nxt;
    logic                 w_err_nxt;
    logic [FRAMES_W-1:0]  w_frames_nxt;
    logic                 w_pend_nxt;

    logic w_shift;
    logic w_commit;
    logic w_hs;
    logic w_full;
    logic w_marker;

    // A commit in the same cycle as a scan-clock rise takes precedence over the shift.
    assign w_shift  = w_sc_rise && w_en_level && !w_en_fall && (r_state != ST_DONE);
    assign w_commit = w_en_fall && (r_state != ST_DONE) && !r_init_done;
    assign w_hs     = r_valid && wr.i_wr_ready;
    assign w_full   = (r_cnt == CNT_W'(FRAME_LEN));
    assign w_marker = w_full && (&r_shreg);

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_state     <= ST_SHIFT;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_hold      <= '0;
            r_valid     <= 1'b0;
            r_init_done <= 1'b0;
            r_frame_err <= 1'b0;
            r_frames    <= '0;
            r_done_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_cnt       <= w_cnt_nxt;
            r_hold      <= w_hold_nxt;
            r_valid     <= w_valid_nxt;
            r_init_done <= w_init_nxt;
            r_frame_err <= w_err_nxt;
            r_frames    <= w_frames_nxt;
            r_done_pend <= w_pend_nxt;
        end
    end

    // Shift, handshake and commit; commit is evaluated last so it sees the handshake outcome.
    always_comb begin
        w_state_nxt  = r_state;
        w_shreg_nxt  = r_shreg;
        w_cnt_nxt    = r_cnt;
        w_hold_nxt   = r_hold;
        w_valid_nxt  = r_valid;
        w_init_nxt   = r_init_done;
        w_err_nxt    = r_frame_err;
        w_frames_nxt = r_frames;
        w_pend_nxt   = r_done_pend;

        if (w_shift && (r_cnt < CNT_W'(FRAME_LEN))) begin
            w_shreg_nxt[r_cnt] = w_si;
            w_cnt_nxt          = r_cnt + CNT_W'(1);
        end

        if (w_hs) begin
            w_valid_nxt = 1'b0;
            w_pend_nxt  = 1'b0;
            w_state_nxt = r_done_pend ? ST_DONE : ST_SHIFT;
            if (r_frames != '1) begin
                w_frames_nxt = r_frames + FRAMES_W'(1);
            end
        end

        if (w_commit) begin
            w_cnt_nxt = '0;
            if (!w_full) begin
                w_err_nxt = 1'b1;
            end else if (w_marker) begin
                w_init_nxt = 1'b1;
                if (r_valid && !w_hs) begin
                    w_pend_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end else if (r_valid) begin
                w_err_nxt = 1'b1;
            end else begin
                w_hold_nxt  = wr_frame_t'(r_shreg);
                w_valid_nxt = 1'b1;
                w_state_nxt = ST_WRITE;
            end
        end
    end

    assign wr.o_wr_valid = r_valid;
    assign wr.o_wr_addr  = r_hold.addr;
    assign wr.o_wr_data  = r_hold.data;
    assign o_init_done   = r_init_done;
    assign o_frame_err   = r_frame_err;
    assign o_frames      = r_frames;

endmodule

// File: tb/tb_scan_sram_loader.sv
// Randomised bench for scan_sram_loader against a frame-level model of the loader.
module tb_scan_sram_loader;
    import scan_sram_loader_pkg::*;

    localparam int unsigned W    = SRAM_WORD_LENGTH;
    localparam int unsigned A    = SRAM_ADDR_WIDTH;
    localparam int unsigned FL   = FRAME_LEN;
    localparam int          MAXF = (1 << FRAMES_W) - 1;

    logic CLK    = 1'b0;
    logic RESETn = 1'b0;
    logic SC_CLK = 1'b0;
    logic SC_EN  = 1'b0;
    logic scanIn = 1'b0;
    logic o_init_done;
    logic o_frame_err;
    logic [FRAMES_W-1:0] o_frames;

    logic ready_fixed = 1'b1;
    logic ready_rnd   = 1'b1;
    bit   rnd_mode    = 1'b0;

    scan_sram_loader_if bus ();
    assign bus.i_wr_ready = rnd_mode ? ready_rnd : ready_fixed;

    scan_sram_loader dut (
        .CLK         (CLK),
        .RESETn      (RESETn),
        .SC_CLK      (SC_CLK),
        .SC_EN       (SC_EN),
        .scanIn      (scanIn),
        .wr          (bus),
        .o_init_done (o_init_done),
        .o_frame_err (o_frame_err),
        .o_frames    (o_frames)
    );

    always #5 CLK = ~CLK;

    // Frame-level model: expected writes in order, plus flag and counter state.
    wr_frame_t      exp_arr [0:255];
    int             wr_idx = 0;
    int             rd_idx = 0;
    int             m_frames = 0;
    bit             m_init = 1'b0;
    bit             m_err  = 1'b0;
    logic [A-1:0]   last_addr = '0;
    logic [W-1:0]   last_data = '0;
    int             cyc = 0;
    int             n_vec = 0;
    int             n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic model_commit(input int n, input logic [63:0] bits);
        logic [FL-1:0] f;
        f = bits[FL-1:0];
        if (m_init) return;
        if (n < int'(FL)) m_err = 1'b1;
        else if (&f) m_init = 1'b1;
        else if (wr_idx != rd_idx) m_err = 1'b1;
        else if (wr_idx < 256) begin
            exp_arr[wr_idx] = wr_frame_t'(f);
            wr_idx++;
        end
    endtask

    task automatic shift_bits(input int n, input logic [63:0] bits, input int hp);
        SC_EN = 1'b1;
        wait_cyc(hp);
        for (int i = 0; i < n; i++) begin
            scanIn = bits[i];
            wait_cyc(hp);
            SC_CLK = 1'b1;
            wait_cyc(hp);
            SC_CLK = 1'b0;
        end
    endtask

    // The commit lands on the third CLK edge after SC_EN falls at the pin.
    task automatic send_frame(input int n, input logic [63:0] bits);
        int hp;
        hp = $urandom_range(4, 7);
        shift_bits(n, bits, hp);
        wait_cyc(hp);
        SC_EN = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        model_commit(n, bits);
        wait_cyc(hp);
    endtask

    function automatic logic [63:0] mk(input logic [A-1:0] addr, input logic [W-1:0] data);
        return 64'({addr, data});
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        RESETn = 1'b0;
        SC_EN  = 1'b0;
        SC_CLK = 1'b0;
        scanIn = 1'b0;
        @(posedge CLK);
        #1;
        chk("rst_valid", 64'(bus.o_wr_valid), 64'(0));
        chk("rst_addr",  64'(bus.o_wr_addr),  64'(0));
        chk("rst_data",  64'(bus.o_wr_data),  64'(0));
        chk("rst_init",  64'(o_init_done),    64'(0));
        chk("rst_err",   64'(o_frame_err),    64'(0));
        chk("rst_frames",64'(o_frames),       64'(0));
        m_init = 1'b0;
        m_err  = 1'b0;
        wr_idx = 0;
        @(negedge CLK);
        RESETn = 1'b1;
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_init"}, 64'(o_init_done), 64'(m_init));
        chk({tag, "_err"},  64'(o_frame_err), 64'(m_err));
    endtask

    // Per-cycle compare of the write port and frame counter against the model.
    task automatic compare_loop();
        forever begin
            @(negedge CLK);
            if (RESETn) begin
                chk("frames", 64'(o_frames), 64'(m_frames));
                if (rd_idx == wr_idx)
                    chk("idle_valid", 64'(bus.o_wr_valid), 64'(0));
                else if (bus.o_wr_valid) begin
                    chk("wr_addr", 64'(bus.o_wr_addr), 64'(exp_arr[rd_idx].addr));
                    chk("wr_data", 64'(bus.o_wr_data), 64'(exp_arr[rd_idx].data));
                end
            end
            if (rnd_mode) ready_rnd = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic pop_loop();
        forever begin
            @(posedge CLK);
            cyc++;
            if (!RESETn) begin
                rd_idx   = 0;
                m_frames = 0;
            end else if (bus.o_wr_valid && bus.i_wr_ready) begin
                last_addr = bus.o_wr_addr;
                last_data = bus.o_wr_data;
                if (rd_idx != wr_idx) rd_idx++;
                if (m_frames < MAXF) m_frames++;
            end
        end
    endtask

    initial begin
        int start;
        logic [W-1:0] d;
        fork
            compare_loop();
            pop_loop();
            begin
                #5_000_000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // Single write with ready held high.
        do_reset();
        send_frame(FL, mk(8'h20, 32'h0000_00FF));
        wait_cyc(5);
        chk("t1_frames", 64'(o_frames), 64'(1));
        chk("t1_addr",   64'(last_addr), 64'(8'h20));
        chk("t1_data",   64'(last_data), 64'(32'h0000_00FF));
        check_flags("t1");

        // 41-bit frame: the trailing extra bit is ignored.
        send_frame(FL + 1, 64'(1) << FL | mk(8'h21, 32'hA5A5_0F0F));
        wait_cyc(5);
        chk("t3_frames", 64'(o_frames), 64'(2));
        chk("t3_addr",   64'(last_addr), 64'(8'h21));
        chk("t3_data",   64'(last_data), 64'(32'hA5A5_0F0F));
        chk("t3_err",    64'(o_frame_err), 64'(0));

        // Short frame sets the error flag; the next full frame still writes.
        send_frame(20, mk(8'h7E, 32'hFFFF_FFFF));
        chk("t4_err", 64'(o_frame_err), 64'(1));
        chk("t4_frames_hold", 64'(o_frames), 64'(2));
        send_frame(FL, mk(8'h22, 32'hDEAD_BEEF));
        wait_cyc(5);
        chk("t4_frames", 64'(o_frames), 64'(3));
        chk("t4_addr",   64'(last_addr), 64'(8'h22));
        check_flags("t4");

        // Back-pressure: second commit while a write is pending is dropped.
        do_reset();
        ready_fixed = 1'b0;
        send_frame(FL, mk(8'h30, 32'h1234_5678));
        start = cyc;
        chk("t5_valid_up", 64'(bus.o_wr_valid), 64'(1));
        chk("t5_err_pre",  64'(o_frame_err), 64'(0));
        send_frame(FL, mk(8'h31, 32'h8765_4321));
        if (cyc - start < 500) wait_cyc(500 - (cyc - start));
        chk("t5_err",     64'(o_frame_err), 64'(1));
        chk("t5_valid",   64'(bus.o_wr_valid), 64'(1));
        chk("t5_addr",    64'(bus.o_wr_addr), 64'(8'h30));
        chk("t5_data",    64'(bus.o_wr_data), 64'(32'h1234_5678));
        chk("t5_frames0", 64'(o_frames), 64'(0));
        ready_fixed = 1'b1;
        wait_cyc(5);
        chk("t5_frames1", 64'(o_frames), 64'(1));
        chk("t5_last",    64'(last_addr), 64'(8'h30));
        chk("t5_valid_dn",64'(bus.o_wr_valid), 64'(0));
        check_flags("t5");

        // Reset mid-frame discards the partial shift.
        do_reset();
        shift_bits(10, 64'($urandom()), 5);
        do_reset();
        send_frame(FL, mk(8'h05, 32'h0BAD_F00D));
        wait_cyc(5);
        chk("t6_frames", 64'(o_frames), 64'(1));
        chk("t6_addr",   64'(last_addr), 64'(8'h05));
        check_flags("t6");

        // 49 random frames with random ready, then the end-of-init marker.
        do_reset();
        rnd_mode = 1'b1;
        for (int a = 0; a <= 8'h30; a++) begin
            d = W'($urandom());
            send_frame(FL, mk(A'(a), d));
        end
        send_frame(FL, 64'hFF_FFFF_FFFF);
        for (int i = 0; i < 200 && rd_idx != wr_idx; i++) @(negedge CLK);
        chk("t2_drained", 64'(rd_idx == wr_idx), 64'(1));
        rnd_mode = 1'b0;
        ready_fixed = 1'b1;
        wait_cyc(5);
        chk("t2_frames", 64'(o_frames), 64'(49));
        chk("t2_init",   64'(o_init_done), 64'(1));
        chk("t2_err",    64'(o_frame_err), 64'(0));
        chk("t2_last",   64'(last_addr), 64'(8'h30));
        check_flags("t2");

        // Scan activity after init is ignored.
        send_frame(FL, mk(8'h10, 32'hCAFE_0001));
        wait_cyc(10);
        chk("t7_init",   64'(o_init_done), 64'(1));
        chk("t7_frames", 64'(o_frames), 64'(49));
        chk("t7_last",   64'(last_addr), 64'(8'h30));
        check_flags("t7");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
